// File: rtl/axil_read_queued_if.sv
// Purpose: AXI4-Lite read channels plus the upstream request/response port of the queued read engine.
// Latency: none, wiring only.
// Backpressure: s_axi_arready/s_axi_rready toward the engine, s_axi_cfg_rready toward upstream.
// Modports: master = engine side (drives AR, R-ready and the upstream results);
//           slave  = interconnect + upstream side (drives AR-ready, R channel and requests).
interface axil_read_queued_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   // AXI4-Lite read address / data channels
   logic [ADDR_W-1:0] s_axi_araddr;
   logic [2:0]        s_axi_arprot;
   logic              s_axi_arvalid;
   logic              s_axi_arready;
   logic [DATA_W-1:0] s_axi_rdata;
   logic [1:0]        s_axi_rresp;
   logic              s_axi_rvalid;
   logic              s_axi_rready;
   // upstream request / result port
   logic              s_axi_cfg_rvalid;
   logic [ADDR_W-1:0] s_axi_cfg_raddr;
   logic              s_axi_cfg_rready;
   logic [DATA_W-1:0] s_axi_cfg_rdata;
   logic [1:0]        s_axi_cfg_rresp;
   logic [ADDR_W-1:0] s_axi_cfg_rdaddr;
   logic              s_axi_cfg_rdv;
   logic              s_axi_cfg_busy;
   logic [15:0]       s_axi_cfg_err_cnt;
   logic              s_axi_cfg_timeout;
   logic              s_axi_cfg_timeout_clr;

   modport master (
      output s_axi_araddr, s_axi_arprot, s_axi_arvalid, s_axi_rready,
      input  s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid,
      input  s_axi_cfg_rvalid, s_axi_cfg_raddr, s_axi_cfg_timeout_clr,
      output s_axi_cfg_rready, s_axi_cfg_rdata, s_axi_cfg_rresp, s_axi_cfg_rdaddr,
      output s_axi_cfg_rdv, s_axi_cfg_busy, s_axi_cfg_err_cnt, s_axi_cfg_timeout
   );

   modport slave (
      input  s_axi_araddr, s_axi_arprot, s_axi_arvalid, s_axi_rready,
      output s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid,
      output s_axi_cfg_rvalid, s_axi_cfg_raddr, s_axi_cfg_timeout_clr,
      input  s_axi_cfg_rready, s_axi_cfg_rdata, s_axi_cfg_rresp, s_axi_cfg_rdaddr,
      input  s_axi_cfg_rdv, s_axi_cfg_busy, s_axi_cfg_err_cnt, s_axi_cfg_timeout
   );
endinterface

// File: rtl/axil_read_queued.sv
// Purpose: queued AXI4-Lite read master; upstream pushes addresses, reads are issued one at a time in order.
// Latency: push in cycle 0 into an idle engine -> arvalid from cycle 2; R handshake in M -> rdv pulse in M+1.
// Backpressure: s_axi_cfg_rready low while the command queue is full; AR/R obey AXI valid/ready.
// Ports: s_axi_aclk / s_axi_areset (sync, active-high) plus the master modport of axil_read_queued_if:
//   AR/R channels to the interconnect, request push (cfg_rvalid/raddr/rready), result
//   (cfg_rdata/rresp/rdaddr/rdv), status (busy, saturating err_cnt, sticky timeout + clear).
module axil_read_queued #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int FIFO_DEPTH = 4,
   parameter int TIMEOUT    = 1024
) (
   input  logic               s_axi_aclk,
   input  logic               s_axi_areset,
   axil_read_queued_if.master bus
);

   localparam int IW = $clog2(FIFO_DEPTH);
   localparam int PW = IW + 1;
   // Counter wide enough to hold TIMEOUT itself so it can park there without wrapping.
   localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RADDR = 2'd1,
      RDATA = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [ADDR_W-1:0] mem_q [FIFO_DEPTH];
   logic [ADDR_W-1:0] mem_d [FIFO_DEPTH];
   logic [ADDR_W-1:0] araddr_q, araddr_d;
   logic              arvalid_q, arvalid_d;
   logic              rready_q, rready_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic [1:0]        rresp_q, rresp_d;
   logic [ADDR_W-1:0] rdaddr_q, rdaddr_d;
   logic              rdv_q, rdv_d;
   logic [15:0]       err_cnt_q, err_cnt_d;
   logic [TW-1:0]     to_cnt_q, to_cnt_d;
   logic              timeout_q, timeout_d;

   logic [PW-1:0]     occ;
   logic              full, empty, push, pop, to_hit;

   // The extra pointer bit distinguishes full from empty when the indices match.
   assign occ   = wr_ptr_q - rd_ptr_q;
   assign full  = (occ == PW'(FIFO_DEPTH));
   assign empty = (occ == '0);
   assign push  = bus.s_axi_cfg_rvalid && !full;
   assign pop   = (state_q == IDLE) && !empty;

   // Fires in the TIMEOUT-th cycle of an outstanding read; the counter then parks so it fires once.
   assign to_hit = (TIMEOUT != 0) && (state_q != IDLE) && (to_cnt_q == TW'(TIMEOUT - 1));

   always_comb begin
      state_d   = state_q;
      wr_ptr_d  = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d  = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
      mem_d     = mem_q;
      araddr_d  = araddr_q;
      arvalid_d = arvalid_q;
      rready_d  = rready_q;
      rdata_d   = rdata_q;
      rresp_d   = rresp_q;
      rdaddr_d  = rdaddr_q;
      rdv_d     = 1'b0;
      err_cnt_d = err_cnt_q;

      if (push) begin
         mem_d[wr_ptr_q[IW-1:0]] = bus.s_axi_cfg_raddr;
      end

      case (state_q)
         IDLE: begin
            if (!empty) begin
               araddr_d  = mem_q[rd_ptr_q[IW-1:0]];
               rdaddr_d  = mem_q[rd_ptr_q[IW-1:0]];
               arvalid_d = 1'b1;
               state_d   = RADDR;
            end
         end
         RADDR: begin
            if (bus.s_axi_arready) begin
               arvalid_d = 1'b0;
               araddr_d  = '0;
               rready_d  = 1'b1;
               state_d   = RDATA;
            end
         end
         RDATA: begin
            if (bus.s_axi_rvalid) begin
               rdata_d  = bus.s_axi_rdata;
               rresp_d  = bus.s_axi_rresp;
               rdv_d    = 1'b1;
               rready_d = 1'b0;
               state_d  = IDLE;
               if (bus.s_axi_rresp != 2'b00 && err_cnt_q != 16'hFFFF) begin
                  err_cnt_d = err_cnt_q + 16'd1;
               end
            end
         end
         default: begin
            state_d   = IDLE;
            arvalid_d = 1'b0;
            araddr_d  = '0;
            rready_d  = 1'b0;
         end
      endcase

      // Cleared on the edge leaving IDLE, so the first outstanding cycle sees zero.
      if (state_q == IDLE) begin
         to_cnt_d = '0;
      end else if (to_cnt_q == TW'(TIMEOUT)) begin
         to_cnt_d = to_cnt_q;
      end else begin
         to_cnt_d = to_cnt_q + TW'(1);
      end

      // Set has priority over clear so a coincident clear never hides a fresh timeout.
      if (to_hit) begin
         timeout_d = 1'b1;
      end else if (bus.s_axi_cfg_timeout_clr) begin
         timeout_d = 1'b0;
      end else begin
         timeout_d = timeout_q;
      end
   end

   always_ff @(posedge s_axi_aclk) begin
      if (s_axi_areset) begin
         state_q   <= IDLE;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         araddr_q  <= '0;
         arvalid_q <= 1'b0;
         rready_q  <= 1'b0;
         rdata_q   <= '0;
         rresp_q   <= '0;
         rdaddr_q  <= '0;
         rdv_q     <= 1'b0;
         err_cnt_q <= '0;
         to_cnt_q  <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         araddr_q  <= araddr_d;
         arvalid_q <= arvalid_d;
         rready_q  <= rready_d;
         rdata_q   <= rdata_d;
         rresp_q   <= rresp_d;
         rdaddr_q  <= rdaddr_d;
         rdv_q     <= rdv_d;
         err_cnt_q <= err_cnt_d;
         to_cnt_q  <= to_cnt_d;
         timeout_q <= timeout_d;
      end
   end

   // Queue storage needs no reset: entries are only read once the pointers say they were written.
   always_ff @(posedge s_axi_aclk) begin
      mem_q <= mem_d;
   end

   assign bus.s_axi_araddr      = araddr_q;
   assign bus.s_axi_arprot      = 3'b000;
   assign bus.s_axi_arvalid     = arvalid_q;
   assign bus.s_axi_rready      = rready_q;
   assign bus.s_axi_cfg_rready  = !full;
   assign bus.s_axi_cfg_rdata   = rdata_q;
   assign bus.s_axi_cfg_rresp   = rresp_q;
   assign bus.s_axi_cfg_rdaddr  = rdaddr_q;
   assign bus.s_axi_cfg_rdv     = rdv_q;
   assign bus.s_axi_cfg_busy    = !empty || (state_q != IDLE);
   assign bus.s_axi_cfg_err_cnt = err_cnt_q;
   assign bus.s_axi_cfg_timeout = timeout_q;

endmodule

// File: tb/tb_axil_read_queued.sv
// Purpose: self-checking bench for axil_read_queued (FIFO_DEPTH=4, TIMEOUT=16).
// Latency: inputs driven and outputs sampled on the falling edge; the slave model reacts 2 time units after the rising edge.
// Backpressure: the slave model can hold arready low and delay rvalid per read.
module tb_axil_read_queued;
   localparam int AW    = 32;
   localparam int DW    = 32;
   localparam int DEPTH = 4;
   localparam int TO    = 16;

   typedef struct { logic [31:0] data; logic [1:0] resp; } rsp_t;
   typedef struct { logic [31:0] addr; logic [31:0] data; logic [1:0] resp; } obs_t;
   typedef struct {
      logic [31:0] addr; logic [31:0] data; logic [1:0] resp;
      int ard; int rd; logic [15:0] exp_err;
   } vec_t;

   logic clk, rst;
   axil_read_queued_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

   axil_read_queued #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH), .TIMEOUT(TO)) dut (
      .s_axi_aclk  (clk),
      .s_axi_areset(rst),
      .bus         (bus.master)
   );

   int checks = 0;
   int errors = 0;

   // slave model state
   logic        sl_arready, sl_rvalid, man_rvalid;
   logic [31:0] sl_rdata, man_rdata;
   logic [1:0]  sl_rresp;
   bit          sl_hold, sl_pend;
   int          sl_ar_dly, sl_r_dly, ar_cnt, r_cnt, ar_hs;
   rsp_t        sl_q[$];
   obs_t        mon_q[$];

   assign bus.s_axi_arready = sl_arready;
   assign bus.s_axi_rvalid  = sl_rvalid | man_rvalid;
   assign bus.s_axi_rdata   = man_rvalid ? man_rdata : sl_rdata;
   assign bus.s_axi_rresp   = sl_rresp;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic chk1(input string nm, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", nm, act, exp);
      end
   endtask

   // AXI slave: samples handshakes on the falling edge, reacts just after the rising edge.
   initial begin
      bit   af, rf;
      rsp_t r;
      sl_arready = 0; sl_rvalid = 0; sl_rdata = '0; sl_rresp = '0;
      sl_pend = 0; ar_cnt = 0; r_cnt = 0; ar_hs = 0;
      forever begin
         @(negedge clk);
         af = bus.s_axi_arvalid && sl_arready;
         rf = sl_rvalid && bus.s_axi_rready;
         @(posedge clk);
         #2;
         if (rst) begin
            sl_arready = 0; sl_rvalid = 0; sl_pend = 0; ar_cnt = 0; r_cnt = 0;
         end else begin
            if (af) begin
               sl_arready = 0; ar_cnt = 0; ar_hs++; sl_pend = 1; r_cnt = 0;
            end
            if (rf) begin
               sl_rvalid = 0; sl_pend = 0;
            end
            if (!sl_arready && bus.s_axi_arvalid && !af && !sl_hold) begin
               if (ar_cnt >= sl_ar_dly) sl_arready = 1;
               else ar_cnt++;
            end
            if (sl_pend && bus.s_axi_rready && !sl_rvalid && !rf) begin
               if (r_cnt >= sl_r_dly) begin
                  sl_rvalid = 1;
                  if (sl_q.size() > 0) begin
                     r = sl_q.pop_front();
                     sl_rdata = r.data; sl_rresp = r.resp;
                  end else begin
                     sl_rdata = '0; sl_rresp = '0;
                  end
               end else begin
                  r_cnt++;
               end
            end
         end
      end
   end

   // Result monitor: records every rdv cycle.
   initial begin
      forever begin
         @(posedge clk);
         #3;
         if (bus.s_axi_cfg_rdv)
            mon_q.push_back('{bus.s_axi_cfg_rdaddr, bus.s_axi_cfg_rdata, bus.s_axi_cfg_rresp});
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Called at a falling edge; returns at the falling edge after acceptance.
   task automatic push(input logic [31:0] a);
      bit ok;
      ok = 0;
      bus.s_axi_cfg_rvalid = 1'b1;
      bus.s_axi_cfg_raddr  = a;
      for (int i = 0; i < 300 && !ok; i++) begin
         ok = bus.s_axi_cfg_rready;
         @(negedge clk);
      end
      bus.s_axi_cfg_rvalid = 1'b0;
      chk1("push_accepted", ok, 1'b1);
   endtask

   task automatic wait_rdv(input string nm, input int n);
      for (int i = 0; i < 400; i++) begin
         if (mon_q.size() >= n) break;
         @(negedge clk);
      end
      chk1(nm, mon_q.size() >= n, 1'b1);
   endtask

   task automatic do_read(input logic [31:0] a, input logic [31:0] d, input logic [1:0] r,
                          input int ard, input int rd, output obs_t o, output int pulses);
      int base;
      base = mon_q.size();
      sl_ar_dly = ard; sl_r_dly = rd;
      sl_q.push_back('{d, r});
      push(a);
      wait_rdv("read_done", base + 1);
      repeat (3) @(negedge clk);
      o = (mon_q.size() > base) ? mon_q[base] : '{'0, '0, '0};
      pulses = mon_q.size() - base;
   endtask

   task automatic timeout_run(input logic [31:0] a, input bit clr_on_hit);
      int base;
      base = mon_q.size();
      sl_ar_dly = 0; sl_r_dly = 20;
      sl_q.push_back('{~a, 2'b00});
      push(a);                       // returns in cycle 1; arvalid rises in cycle 2
      repeat (16) @(negedge clk);    // cycle 17: last cycle before the flag
      chk1("to_before", bus.s_axi_cfg_timeout, 1'b0);
      if (clr_on_hit) bus.s_axi_cfg_timeout_clr = 1'b1;
      @(negedge clk);                // cycle 18
      bus.s_axi_cfg_timeout_clr = 1'b0;
      chk1("to_set", bus.s_axi_cfg_timeout, 1'b1);
      chk1("to_still_busy", bus.s_axi_cfg_busy, 1'b1);
      wait_rdv("to_read_done", base + 1);
      if (mon_q.size() > base) chk("to_rdata", mon_q[base].data, ~a);
      repeat (2) @(negedge clk);
   endtask

   vec_t vt[6];
   obs_t o;
   int   pulses, base, acc, fell, stall_bad, seen_av, hs0;

   initial begin
      vt[0] = '{32'h0000_0010, 32'hDEAD_BEEF, 2'b00, 1, 3, 16'd0};
      vt[1] = '{32'h0000_0020, 32'h1111_1111, 2'b10, 0, 0, 16'd1};
      vt[2] = '{32'h0000_0024, 32'h2222_2222, 2'b10, 2, 1, 16'd2};
      vt[3] = '{32'h0000_0028, 32'h3333_3333, 2'b10, 0, 2, 16'd3};
      vt[4] = '{32'h0000_002C, 32'h4444_4444, 2'b00, 1, 0, 16'd3};
      vt[5] = '{32'h0000_0030, 32'h5555_5555, 2'b01, 3, 4, 16'd4};

      rst = 1'b1; sl_hold = 0; sl_ar_dly = 0; sl_r_dly = 0; man_rvalid = 0; man_rdata = '0;
      bus.s_axi_cfg_rvalid = 0; bus.s_axi_cfg_raddr = '0; bus.s_axi_cfg_timeout_clr = 0;
      repeat (3) @(negedge clk);

      // reset state
      chk1("rst_arvalid", bus.s_axi_arvalid, 1'b0);
      chk1("rst_rready", bus.s_axi_rready, 1'b0);
      chk("rst_araddr", bus.s_axi_araddr, 32'h0);
      chk1("rst_rdv", bus.s_axi_cfg_rdv, 1'b0);
      chk1("rst_busy", bus.s_axi_cfg_busy, 1'b0);
      chk("rst_err_cnt", 32'(bus.s_axi_cfg_err_cnt), 32'h0);
      chk1("rst_timeout", bus.s_axi_cfg_timeout, 1'b0);
      chk("rst_rdata", bus.s_axi_cfg_rdata, 32'h0);
      chk("rst_rdaddr", bus.s_axi_cfg_rdaddr, 32'h0);
      chk("rst_arprot", 32'(bus.s_axi_arprot), 32'h0);
      rst = 1'b0;
      @(negedge clk);
      chk1("rst_cfg_rready", bus.s_axi_cfg_rready, 1'b1);

      // cycle-exact latency: push in c0, arready in c4, rvalid in c5
      sl_ar_dly = 2; sl_r_dly = 0;
      sl_q.push_back('{32'hA5A5_0040, 2'b00});
      bus.s_axi_cfg_rvalid = 1; bus.s_axi_cfg_raddr = 32'h40;
      chk1("lat_c0_rready", bus.s_axi_cfg_rready, 1'b1);
      @(negedge clk);
      bus.s_axi_cfg_rvalid = 0;
      chk1("lat_c1_arvalid", bus.s_axi_arvalid, 1'b0);
      chk1("lat_c1_busy", bus.s_axi_cfg_busy, 1'b1);
      @(negedge clk);
      chk1("lat_c2_arvalid", bus.s_axi_arvalid, 1'b1);
      chk("lat_c2_araddr", bus.s_axi_araddr, 32'h40);
      repeat (2) @(negedge clk);
      chk1("lat_c4_rready", bus.s_axi_rready, 1'b0);
      @(negedge clk);
      chk1("lat_c5_rready", bus.s_axi_rready, 1'b1);
      chk1("lat_c5_arvalid", bus.s_axi_arvalid, 1'b0);
      chk("lat_c5_araddr", bus.s_axi_araddr, 32'h0);
      @(negedge clk);
      chk1("lat_c6_rdv", bus.s_axi_cfg_rdv, 1'b1);
      chk("lat_c6_rdaddr", bus.s_axi_cfg_rdaddr, 32'h40);
      chk("lat_c6_rdata", bus.s_axi_cfg_rdata, 32'hA5A5_0040);
      chk1("lat_c6_rready", bus.s_axi_rready, 1'b0);
      chk1("lat_c6_busy", bus.s_axi_cfg_busy, 1'b0);
      @(negedge clk);
      chk1("lat_c7_rdv", bus.s_axi_cfg_rdv, 1'b0);
      chk("lat_c7_rdata_hold", bus.s_axi_cfg_rdata, 32'hA5A5_0040);

      // table: single reads with varied delays and response codes
      for (int i = 0; i < 6; i++) begin
         do_read(vt[i].addr, vt[i].data, vt[i].resp, vt[i].ard, vt[i].rd, o, pulses);
         chk($sformatf("vec%0d_pulses", i), pulses, 1);
         chk($sformatf("vec%0d_rdaddr", i), o.addr, vt[i].addr);
         chk($sformatf("vec%0d_rdata", i), o.data, vt[i].data);
         chk($sformatf("vec%0d_rresp", i), 32'(o.resp), 32'(vt[i].resp));
         chk($sformatf("vec%0d_err_cnt", i), 32'(bus.s_axi_cfg_err_cnt), 32'(vt[i].exp_err));
      end

      // queue fill with arready held low, AR stall stability, in-order return
      sl_hold = 1; sl_ar_dly = 0; sl_r_dly = 1;
      for (int k = 0; k < 6; k++) sl_q.push_back('{~(32'h100 + 32'(4 * k)), 2'b00});
      base = mon_q.size(); hs0 = ar_hs;
      acc = 0; fell = -1; stall_bad = 0; seen_av = 0;
      bus.s_axi_cfg_rvalid = 1; bus.s_axi_cfg_raddr = 32'h100;
      for (int c = 0; c < 20; c++) begin
         if (bus.s_axi_cfg_rready) acc++;
         else if (fell < 0) fell = acc;
         if (bus.s_axi_arvalid) begin
            seen_av++;
            if (bus.s_axi_araddr !== 32'h100) stall_bad++;
         end
         @(negedge clk);
         bus.s_axi_cfg_raddr = 32'h100 + 32'(4 * acc);
      end
      chk("fill_accepted", acc, 5);
      chk("fill_rready_fell_after", fell, 5);
      chk("stall_arvalid_cycles", seen_av, 18);
      chk("stall_unstable_cycles", stall_bad, 0);
      chk("stall_no_handshake", ar_hs - hs0, 0);
      chk1("fill_timeout_set", bus.s_axi_cfg_timeout, 1'b1);
      sl_hold = 0;
      push(32'h114);
      wait_rdv("fill_all_done", base + 6);
      repeat (3) @(negedge clk);
      for (int k = 0; k < 6; k++) begin
         if (mon_q.size() > base + k) begin
            chk($sformatf("fill%0d_addr", k), mon_q[base + k].addr, 32'h100 + 32'(4 * k));
            chk($sformatf("fill%0d_data", k), mon_q[base + k].data, ~(32'h100 + 32'(4 * k)));
         end
      end
      chk("fill_ar_handshakes", ar_hs - hs0, 6);
      chk("fill_pulses", mon_q.size() - base, 6);

      // timeout: clear, natural set, then set coinciding with clear
      bus.s_axi_cfg_timeout_clr = 1;
      @(negedge clk);
      bus.s_axi_cfg_timeout_clr = 0;
      chk1("to_cleared", bus.s_axi_cfg_timeout, 1'b0);
      timeout_run(32'h80, 1'b0);
      bus.s_axi_cfg_timeout_clr = 1;
      @(negedge clk);
      bus.s_axi_cfg_timeout_clr = 0;
      chk1("to_cleared2", bus.s_axi_cfg_timeout, 1'b0);
      timeout_run(32'h84, 1'b1);

      // error counter saturation
      force dut.err_cnt_q = 16'hFFFE;
      repeat (2) @(negedge clk);
      release dut.err_cnt_q;
      @(negedge clk);
      chk("sat_preload", 32'(bus.s_axi_cfg_err_cnt), 32'hFFFE);
      do_read(32'h90, 32'h9090_9090, 2'b10, 0, 0, o, pulses);
      chk("sat_reach", 32'(bus.s_axi_cfg_err_cnt), 32'hFFFF);
      chk("sat_rresp", 32'(o.resp), 32'd2);
      do_read(32'h94, 32'h9494_9494, 2'b11, 0, 0, o, pulses);
      chk("sat_hold", 32'(bus.s_axi_cfg_err_cnt), 32'hFFFF);

      // reset while in RDATA with two entries queued
      sl_ar_dly = 0; sl_r_dly = 50;
      push(32'hA0);
      push(32'hA4);
      push(32'hA8);
      chk1("mid_rready_before", bus.s_axi_rready, 1'b1);
      chk1("mid_busy_before", bus.s_axi_cfg_busy, 1'b1);
      base = mon_q.size();
      rst = 1;
      @(negedge clk);
      rst = 0;
      chk1("mid_arvalid", bus.s_axi_arvalid, 1'b0);
      chk1("mid_rready", bus.s_axi_rready, 1'b0);
      chk1("mid_busy", bus.s_axi_cfg_busy, 1'b0);
      chk("mid_err_cnt", 32'(bus.s_axi_cfg_err_cnt), 32'h0);
      chk1("mid_timeout", bus.s_axi_cfg_timeout, 1'b0);
      man_rdata = 32'hBAD0_BAD0; man_rvalid = 1;
      repeat (3) @(negedge clk);
      man_rvalid = 0;
      repeat (2) @(negedge clk);
      chk("mid_late_rvalid_pulses", mon_q.size() - base, 0);
      chk1("mid_idle_arvalid", bus.s_axi_arvalid, 1'b0);
      sl_q.delete();
      do_read(32'h200, 32'h1234_5678, 2'b00, 1, 1, o, pulses);
      chk("post_rst_rdaddr", o.addr, 32'h200);
      chk("post_rst_rdata", o.data, 32'h1234_5678);
      chk("post_rst_pulses", pulses, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/axil_read_queued.md
# axil_read_queued

Parametrised AXI4-Lite read master: the next generation of the single-shot configuration read engine. Upstream logic pushes read addresses into a command queue of depth FIFO_DEPTH without waiting for completion. The block drains the queue one AXI4-Lite read at a time and returns data, response code and the matching address for each read. It also keeps a saturating error counter and a sticky per-transaction timeout flag. It sits between the register-access controller and the AXI4-Lite interconnect.

## Interface
- ADDR_W, 32, address width (≥ 2)
- DATA_W, 32, data width (32 or 64)
- FIFO_DEPTH, 4, command queue entries (power of 2, ≥ 2)
- TIMEOUT, 1024, cycles an outstanding read may take before the timeout flag sets; 0 disables the timeout
- Clocking: one clock; reset is synchronous and active-high.
- s_axi_aclk  in  1  clock
- s_axi_areset  in  1  synchronous, active-high reset
- s_axi_araddr  out  ADDR_W  AXI read address
- s_axi_arprot  out  3  constant 3'b000
- s_axi_arvalid  out  1  AXI address valid
- s_axi_arready  in  1  AXI address ready
- s_axi_rdata  in  DATA_W  AXI read data
- s_axi_rresp  in  2  AXI read response
- s_axi_rvalid  in  1  AXI read valid
- s_axi_rready  out  1  AXI read ready
- s_axi_cfg_rvalid  in  1  request valid
- s_axi_cfg_raddr  in  ADDR_W  request address
- s_axi_cfg_rready  out  1  request ready; high when the queue is not full
- s_axi_cfg_rdata  out  DATA_W  returned data
- s_axi_cfg_rresp  out  2  returned response code
- s_axi_cfg_rdaddr  out  ADDR_W  address of the returned read
- s_axi_cfg_rdv  out  1  one-cycle pulse; the three outputs above are valid while it is high
- s_axi_cfg_busy  out  1  high when the queue is non-empty or a read is in flight
- s_axi_cfg_err_cnt  out  16  count of non-OKAY responses, saturating
- s_axi_cfg_timeout  out  1  sticky timeout flag
- s_axi_cfg_timeout_clr  in  1  clears the timeout flag

## Operation
- Queue
  - A request is accepted when s_axi_cfg_rvalid && s_axi_cfg_rready.
  - The queue is a circular buffer with log2(FIFO_DEPTH)+1-bit pointers; full when the pointer difference equals FIFO_DEPTH.
  - A request presented while full is not accepted and is not lost; upstream holds it.
- FSM states: IDLE, RADDR, RDATA.
  - IDLE: if the queue is non-empty, pop the head. Register the head into s_axi_araddr and s_axi_cfg_rdaddr, set s_axi_arvalid=1, go to RADDR. Otherwise stay in IDLE.
  - RADDR: hold s_axi_araddr and s_axi_arvalid stable until s_axi_arready. On the handshake edge: s_axi_arvalid<=0, s_axi_araddr<=0, s_axi_rready<=1, go to RDATA.
  - RDATA: hold s_axi_rready=1. On s_axi_rvalid: capture s_axi_rdata and s_axi_rresp, pulse s_axi_cfg_rdv, s_axi_rready<=0, go to IDLE.
  - Any illegal state encoding goes to IDLE.
- Only one AXI read is outstanding at a time. Responses return in request order.
- Error counter: increments on every R handshake with s_axi_rresp != 2'b00. It holds at 16'hFFFF and clears only on reset.
- Timeout
  - A counter clears on leaving IDLE and increments each cycle in RADDR or RDATA.
  - When it reaches TIMEOUT (and TIMEOUT != 0), s_axi_cfg_timeout sets.
  - The transaction is not aborted; AXI handshakes stay protocol-legal.
  - s_axi_cfg_timeout_clr clears the flag. If set and clear occur in the same cycle, set wins.
- s_axi_cfg_rdata and s_axi_cfg_rresp hold their last value between pulses.

## Timing
- Reset values
  - Outputs: s_axi_araddr=0, s_axi_arvalid=0, s_axi_rready=0, s_axi_cfg_rdata=0, s_axi_cfg_rresp=0, s_axi_cfg_rdaddr=0, s_axi_cfg_rdv=0, s_axi_cfg_busy=0, s_axi_cfg_err_cnt=0, s_axi_cfg_timeout=0.
  - Internal: FSM in IDLE, queue empty.
  - s_axi_cfg_rready is 1 from the first cycle after reset.
- Reset mid-transaction: s_axi_arvalid and s_axi_rready drop at the next edge and the queue is flushed. A late s_axi_rvalid from the slave produces no s_axi_cfg_rdv.
- Request accepted in cycle 0 into an empty queue with the FSM idle: s_axi_arvalid is high from cycle 2.
- s_axi_arready in cycle N: s_axi_rready is high from cycle N+1.
- R handshake in cycle M: s_axi_cfg_rdv is high in cycle M+1 only. The FSM is in IDLE in cycle M+1, and the next s_axi_arvalid rises in cycle M+2.
- Push and pop in the same cycle: both take effect and the occupancy is unchanged.
- s_axi_cfg_busy is combinational from queue occupancy and FSM state.

## Test plan
- Single read: push 0x0000_0010; slave gives arready 1 cycle after arvalid, rvalid 3 cycles later with rdata 0xDEADBEEF, rresp 0 -> rdv pulses once with rdata 0xDEADBEEF, rdaddr 0x10, rresp 0, err_cnt stays 0.
- Queue fill: hold arready=0 and push 6 addresses back-to-back with FIFO_DEPTH=4 -> s_axi_cfg_rready falls after 5 acceptances (4 queued, 1 in flight). Release arready -> all 6 reads return in push order.
- Error responses: return rresp=2'b10 on 3 reads -> err_cnt=3 and rresp is reported per read. Force err_cnt to 16'hFFFF with one more error -> it stays 16'hFFFF.
- Timeout: TIMEOUT=16, slave delays rvalid by 20 cycles -> timeout sets in cycle 16 of the outstanding read and the read still completes normally. Assert clr on the same cycle as a new set event -> the flag remains 1.
- Reset mid-read: assert s_axi_areset while in RDATA with 2 entries queued -> next cycle arvalid=0, rready=0, busy=0. A later rvalid yields no rdv.
- Stall hold: arready low for 10 cycles -> araddr and arvalid are bit-stable throughout; the address handshake occurs exactly once.
